// File: rtl/pipe_hazard_if.sv
// Datapath <-> hazard-control signal bundle; counter signals exist only with HAZ_PERF_CNT_EN.
interface pipe_hazard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    typedef logic [CNT_W-1:0] cnt_t;

    logic             ihit, dhit, mem_dreq;
    logic             ex_dren, dc_use_rt;
    logic [REG_W-1:0] ex_wsel, dc_rsel1, dc_rsel2;
    logic             br_taken, halt_mem;
    logic             pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
    logic             flushed1, flushed2, flushed3;
    logic             halt_out;
`ifdef HAZ_PERF_CNT_EN
    cnt_t             stall_cnt, bubble_cnt, flush_cnt;
`endif

    modport master (
        output ihit, dhit, mem_dreq, ex_dren, dc_use_rt, ex_wsel, dc_rsel1, dc_rsel2,
               br_taken, halt_mem,
        input  pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
               flushed1, flushed2, flushed3, halt_out
`ifdef HAZ_PERF_CNT_EN
        , input stall_cnt, bubble_cnt, flush_cnt
`endif
    );

    modport slave (
        input  ihit, dhit, mem_dreq, ex_dren, dc_use_rt, ex_wsel, dc_rsel1, dc_rsel2,
               br_taken, halt_mem,
        output pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
               flushed1, flushed2, flushed3, halt_out
`ifdef HAZ_PERF_CNT_EN
        , output stall_cnt, bubble_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/bubble control for the four stage latches.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input logic          CLK,
    input logic          nRST,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam logic [REG_W-1:0] R0 = '0;

    state_t state, nstate;
    logic   live, br_pend, br_pend_n;
    logic   act, dwait, redirect, lu;

    always_comb begin
        act      = live && (state != HALT);
        dwait    = act && !hz.dhit && (hz.mem_dreq || state == DWAIT);
        redirect = hz.br_taken || br_pend;
        lu       = hz.ex_dren && (hz.ex_wsel != R0) &&
                   ((hz.ex_wsel == hz.dc_rsel1) || (hz.dc_use_rt && hz.ex_wsel == hz.dc_rsel2));
    end

    always_comb begin
        nstate      = state;
        br_pend_n   = br_pend;
        hz.pc_en    = 1'b0;
        hz.pipe1_en = 1'b0;
        hz.pipe2_en = 1'b0;
        hz.pipe3_en = 1'b0;
        hz.pipe4_en = 1'b0;
        hz.flushed1 = 1'b0;
        hz.flushed2 = 1'b0;
        hz.flushed3 = 1'b0;
        if (act) begin
            if (dwait) begin
                // Redirect seen during a data wait is remembered, applied on the dhit cycle.
                nstate = DWAIT;
                if (hz.br_taken) br_pend_n = 1'b1;
            end else begin
                nstate      = RUN;
                hz.pc_en    = 1'b1;
                hz.pipe1_en = 1'b1;
                hz.pipe2_en = 1'b1;
                hz.pipe3_en = 1'b1;
                hz.pipe4_en = 1'b1;
                if (redirect) begin
                    br_pend_n   = 1'b0;
                    hz.flushed1 = 1'b1;
                    hz.flushed2 = 1'b1;
                    hz.flushed3 = 1'b1;
                end else if (lu) begin
                    hz.pc_en    = 1'b0;
                    hz.pipe1_en = 1'b0;
                    hz.flushed2 = 1'b1;
                end else if (!hz.ihit) begin
                    hz.pc_en    = 1'b0;
                    hz.flushed1 = 1'b1;
                end
            end
            if (hz.halt_mem) nstate = HALT;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= RUN;
            live    <= 1'b0;
            br_pend <= 1'b0;
        end else begin
            state   <= nstate;
            live    <= 1'b1;
            br_pend <= br_pend_n;
        end
    end

    assign hz.halt_out = (state == HALT);

`ifdef HAZ_PERF_CNT_EN
    cnt_t stall_q, bubble_q, flush_q;
    logic bubble_ev, flush_ev;

    assign bubble_ev = act && !dwait && !redirect && lu;
    assign flush_ev  = act && !dwait && redirect;

    // Saturating counters; cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (dwait && stall_q != '1)      stall_q  <= stall_q + 1'b1;
            if (bubble_ev && bubble_q != '1) bubble_q <= bubble_q + 1'b1;
            if (flush_ev && flush_q != '1)   flush_q  <= flush_q + 1'b1;
        end
    end

    assign hz.stall_cnt  = stall_q;
    assign hz.bubble_cnt = bubble_q;
    assign hz.flush_cnt  = flush_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; counter checks compile in with HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;
    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_if #(.REG_W(5), .CNT_W(32)) hif ();
    pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (.CLK(CLK), .nRST(nRST), .hz(hif.slave));

    // {pc_en, pipe1..4_en, flushed1..3, halt_out}
    localparam logic [8:0] ZERO  = 9'b0_0000_000_0;
    localparam logic [8:0] NORM  = 9'b1_1111_000_0;
    localparam logic [8:0] LU    = 9'b0_0111_010_0;
    localparam logic [8:0] FLUSH = 9'b1_1111_111_0;
    localparam logic [8:0] IFW   = 9'b0_1111_100_0;
    localparam logic [8:0] HALTV = 9'b0_0000_000_1;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;
    sb_t sbq[$];

    logic [8:0] obs;
    assign obs = {hif.pc_en, hif.pipe1_en, hif.pipe2_en, hif.pipe3_en, hif.pipe4_en,
                  hif.flushed1, hif.flushed2, hif.flushed3, hif.halt_out};

    task automatic drive(input logic ih, input logic dh, input logic mr, input logic ed,
                         input logic [4:0] ws, input logic [4:0] r1, input logic [4:0] r2,
                         input logic ur, input logic br, input logic hm);
        hif.ihit = ih; hif.dhit = dh; hif.mem_dreq = mr; hif.ex_dren = ed;
        hif.ex_wsel = ws; hif.dc_rsel1 = r1; hif.dc_rsel2 = r2; hif.dc_use_rt = ur;
        hif.br_taken = br; hif.halt_mem = hm;
    endtask

    task automatic push(input string tag, input logic [8:0] e);
        sb_t it;
        it.tag = tag;
        it.exp = e;
        sbq.push_back(it);
    endtask

    task automatic pop_cmp();
        sb_t it;
        it = sbq.pop_front();
        checks++;
        assert (obs === it.exp) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", it.tag, obs, it.exp);
        end
    endtask

    // Check now (no clock advance).
    task automatic now_chk(input string tag, input logic [8:0] e);
        push(tag, e);
        #1;
        pop_cmp();
    endtask

    // Check mid-cycle, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [8:0] e);
        push(tag, e);
        #3;
        pop_cmp();
        @(posedge CLK);
        #1;
    endtask

    task automatic chkc(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
        end
    endtask

    initial begin
        nRST = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        now_chk("rst", ZERO);
        nRST = 1'b1;
        now_chk("prelive", ZERO);
        @(posedge CLK);
        #1;
        cyc("norm", NORM);

        // load-use on rt, then the load leaves EX
        drive(1, 0, 0, 1, 5, 3, 5, 1, 0, 0);  cyc("lu_rt", LU);
        drive(1, 0, 0, 0, 5, 3, 5, 1, 0, 0);  cyc("lu_next", NORM);
        drive(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);  cyc("lu_r0", NORM);
        drive(1, 0, 0, 1, 7, 7, 2, 0, 0, 0);  cyc("lu_rs", LU);
        drive(1, 0, 0, 1, 9, 1, 9, 0, 0, 0);  cyc("lu_rt_unused", NORM);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("ifw", IFW);

        // data wait: 3 stall cycles then one advance
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("dw0", ZERO); cyc("dw1", ZERO); cyc("dw2", ZERO);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);  cyc("dw_hit", NORM);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
        chkc("stall_cnt3", hif.stall_cnt, 3);
`endif
        cyc("dw_after", NORM);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("dhit_noreq", NORM);

        // redirects during a data wait collapse to one flush on the dhit cycle
        drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 0);  cyc("bw0", ZERO);
        cyc("bw1", ZERO);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);  cyc("bw2", ZERO);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);  cyc("bw_hit", FLUSH);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
        chkc("flush_cnt1", hif.flush_cnt, 1);
`endif
        cyc("bw_after", NORM);

        // branch beats load-use
        drive(1, 0, 0, 1, 5, 5, 0, 0, 1, 0);  cyc("br_lu", FLUSH);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("br_lu_after", NORM);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("br_ifw", FLUSH);
`ifdef HAZ_PERF_CNT_EN
        chkc("stall_cnt6", hif.stall_cnt, 6);
        chkc("bubble_cnt2", hif.bubble_cnt, 2);
        chkc("flush_cnt3", hif.flush_cnt, 3);
`endif

        // halt is sticky until reset
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);  cyc("halt_in", NORM);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("halt1", HALTV);
        drive(0, 0, 1, 1, 5, 5, 0, 0, 1, 0);  cyc("halt2", HALTV);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("halt3", HALTV);
        nRST = 1'b0;
        now_chk("arst", ZERO);
`ifdef HAZ_PERF_CNT_EN
        chkc("stall_rst", hif.stall_cnt, 0);
        chkc("flush_rst", hif.flush_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
